// File: rtl/multi_channel_request_tracker_pkg.sv
// Shared types and default constants for the multi-channel request tracker.
package multi_channel_request_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BUSY    = 2'd2
  } state_t;

  localparam int DEF_BUSY_LEN = 8;
  localparam int DEF_TIMEOUT  = 16;
  localparam int CNT_W        = 8;

endpackage

// File: rtl/multi_channel_request_tracker_channel.sv
// One request-tracking channel: IDLE -> PENDING -> BUSY (or back to IDLE on cancel).
// Optional PENDING timeout enabled by defining REQUEST_TRACKER_TIMEOUT_EN.
module request_tracker_channel
  import multi_channel_request_tracker_pkg::*;
#(
  parameter int BUSY_LEN = DEF_BUSY_LEN,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic request,
  input  logic accept,
  input  logic cancel,
  output logic busy,
  output logic done,
  output logic aborted,
  output logic timed_out,
  output logic pending
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bcnt, bcnt_nxt;
  logic             aborted_q, aborted_nxt;
  logic             to_hit;

`ifdef REQUEST_TRACKER_TIMEOUT_EN
  logic [CNT_W-1:0] pcnt;
  logic             timed_out_q;

  // pcnt holds (PENDING cycles so far - 1); it restarts at 0 on every entry to PENDING
  assign to_hit = (state == PENDING) && !accept && !cancel &&
                  (pcnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      timed_out_q <= 1'b0;
    end else begin
      pcnt        <= (state == PENDING) ? pcnt + CNT_W'(1) : '0;
      timed_out_q <= to_hit;
    end
  end

  assign timed_out = timed_out_q;
`else
  logic unused_timeout;
  assign unused_timeout = |CNT_W'(TIMEOUT);
  assign to_hit         = 1'b0;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcnt      <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bcnt      <= bcnt_nxt;
      aborted_q <= aborted_nxt;
    end
  end

  // cancel beats accept, and both beat the timeout
  always_comb begin
    state_nxt   = state;
    bcnt_nxt    = bcnt;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (request) state_nxt = PENDING;
      end
      PENDING: begin
        if (cancel) begin
          state_nxt   = IDLE;
          aborted_nxt = 1'b1;
        end else if (accept) begin
          state_nxt = BUSY;
          bcnt_nxt  = CNT_W'(BUSY_LEN - 1);
        end else if (to_hit) begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (bcnt == '0) state_nxt = IDLE;
        else            bcnt_nxt  = bcnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == BUSY);
  assign done    = (state == BUSY) && (bcnt == '0);
  assign aborted = aborted_q;
  assign pending = (state == PENDING);

endmodule

// File: rtl/multi_channel_request_tracker.sv
// NUM_CH independent request trackers plus a count of channels waiting in PENDING.
// Define REQUEST_TRACKER_TIMEOUT_EN to enable the per-channel PENDING timeout.
module multi_channel_request_tracker
  import multi_channel_request_tracker_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int BUSY_LEN = DEF_BUSY_LEN,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           request,
  input  logic [NUM_CH-1:0]           accept,
  input  logic [NUM_CH-1:0]           cancel,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           done,
  output logic [NUM_CH-1:0]           aborted,
  output logic [NUM_CH-1:0]           timed_out,
  output logic [$clog2(NUM_CH+1)-1:0] pending_count
);

  localparam int PC_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] pending;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    request_tracker_channel #(
      .BUSY_LEN (BUSY_LEN),
      .TIMEOUT  (TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .request   (request[i]),
      .accept    (accept[i]),
      .cancel    (cancel[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .aborted   (aborted[i]),
      .timed_out (timed_out[i]),
      .pending   (pending[i])
    );
  end

  // popcount of the registered PENDING flags, so it tracks state in the same cycle
  always_comb begin
    pending_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pending_count = pending_count + PC_W'(pending[i]);
    end
  end

endmodule

// File: tb/tb_multi_channel_request_tracker.sv
// Scoreboard bench for multi_channel_request_tracker (NUM_CH=4, BUSY_LEN=8, TIMEOUT=16).
module tb_multi_channel_request_tracker;

  localparam int NCH  = 4;
  localparam int BLEN = 8;
  localparam int TOUT = 16;
  localparam int PCW  = 3;
`ifdef REQUEST_TRACKER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] request, accept, cancel;
  logic [NCH-1:0] busy, done, aborted, timed_out;
  logic [PCW-1:0] pending_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic [NCH-1:0] aborted;
    logic [NCH-1:0] timed_out;
    logic [PCW-1:0] pc;
  } exp_t;

  exp_t sb[$];

  // reference model: mode 0=idle 1=pending 2=busy; rem = busy cycles left incl. current; age = pending cycle number
  int m_mode[NCH];
  int m_rem[NCH];
  int m_age[NCH];
  bit m_ab[NCH];
  bit m_to[NCH];
  int n_busy[NCH], n_done[NCH], n_ab[NCH], n_to[NCH];

  multi_channel_request_tracker #(
    .NUM_CH   (NCH),
    .BUSY_LEN (BLEN),
    .TIMEOUT  (TOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .request       (request),
    .accept        (accept),
    .cancel        (cancel),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .timed_out     (timed_out),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCH; g++) begin : g_prop
    busy_guard: assert property (@(posedge clk) disable iff (!rst_n)
      $rose(busy[g]) |-> $past(dut.pending[g] && accept[g] && !cancel[g]))
      else check("busy_guard", 32'(busy[g]), 32'd0);
  end

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0; m_rem[i] = 0; m_age[i] = 0; m_ab[i] = 1'b0; m_to[i] = 1'b0;
    end
  endtask

  task automatic clear_tallies();
    for (int i = 0; i < NCH; i++) begin
      n_busy[i] = 0; n_done[i] = 0; n_ab[i] = 0; n_to[i] = 0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] rq, input logic [NCH-1:0] ac,
                            input logic [NCH-1:0] cn);
    for (int i = 0; i < NCH; i++) begin
      m_ab[i] = 1'b0;
      m_to[i] = 1'b0;
      if (m_mode[i] == 0) begin
        if (rq[i]) begin m_mode[i] = 1; m_age[i] = 1; end
      end else if (m_mode[i] == 1) begin
        if (cn[i]) begin
          m_mode[i] = 0; m_ab[i] = 1'b1;
        end else if (ac[i]) begin
          m_mode[i] = 2; m_rem[i] = BLEN;
        end else if (TO_EN && m_age[i] == TOUT) begin
          m_mode[i] = 0; m_to[i] = 1'b1;
        end else begin
          m_age[i]++;
        end
      end else begin
        if (m_rem[i] == 1) m_mode[i] = 0;
        else               m_rem[i]--;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      e.busy[i]      = (m_mode[i] == 2);
      e.done[i]      = (m_mode[i] == 2) && (m_rem[i] == 1);
      e.aborted[i]   = m_ab[i];
      e.timed_out[i] = m_to[i];
      if (m_mode[i] == 1) e.pc = e.pc + PCW'(1);
    end
    return e;
  endfunction

  // drive one cycle of stimulus at the negedge, compare #1 after the following posedge
  task automatic step(input logic [NCH-1:0] rq, input logic [NCH-1:0] ac,
                      input logic [NCH-1:0] cn);
    exp_t e;
    request = rq; accept = ac; cancel = cn;
    model_step(rq, ac, cn);
    sb.push_back(model_out());
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("busy",          32'(busy),          32'(e.busy));
      check("done",          32'(done),          32'(e.done));
      check("aborted",       32'(aborted),       32'(e.aborted));
      check("timed_out",     32'(timed_out),     32'(e.timed_out));
      check("pending_count", 32'(pending_count), 32'(e.pc));
    end
    for (int i = 0; i < NCH; i++) begin
      if (busy[i])      n_busy[i]++;
      if (done[i])      n_done[i]++;
      if (aborted[i])   n_ab[i]++;
      if (timed_out[i]) n_to[i]++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(busy),          32'd0);
    check({tag, "_done"},    32'(done),          32'd0);
    check({tag, "_aborted"}, 32'(aborted),       32'd0);
    check({tag, "_to"},      32'(timed_out),     32'd0);
    check({tag, "_pc"},      32'(pending_count), 32'd0);
  endtask

  // reset applied mid-cycle: outputs must clear at once and stay clear with no pulses
  task automatic async_reset(input string tag);
    request = '0; accept = '0; cancel = '0;
    rst_n = 1'b0;
    #1;
    check_all_zero({tag, "_now"});
    model_reset();
    sb.delete();
    @(posedge clk); #1;
    check_all_zero({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; request = '0; accept = '0; cancel = '0;
    model_reset();
    clear_tallies();
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // request ch0 at cycle 0, accept at cycle 3: busy 4..11, done at 11
    clear_tallies();
    step(4'b0001, '0, '0); idle(2); step('0, 4'b0001, '0); idle(10);
    check("a_busy_cycles", 32'(n_busy[0]), 32'd8);
    check("a_done_count",  32'(n_done[0]), 32'd1);

    // cancel ch1 at cycle 2, then accept+cancel together
    clear_tallies();
    step(4'b0010, '0, '0); idle(1); step('0, '0, 4'b0010); idle(3);
    check("b_aborted", 32'(n_ab[1]),   32'd1);
    check("b_busy",    32'(n_busy[1]), 32'd0);
    clear_tallies();
    step(4'b0010, '0, '0); idle(1); step('0, 4'b0010, 4'b0010); idle(3);
    check("b2_aborted", 32'(n_ab[1]),   32'd1);
    check("b2_busy",    32'(n_busy[1]), 32'd0);

    // accept in the request cycle is ignored: ch2 stays PENDING
    clear_tallies();
    step(4'b0100, 4'b0100, '0); idle(6);
    check("c_pending", 32'(pending_count), 32'd1);
    check("c_busy",    32'(n_busy[2]),     32'd0);
    step('0, '0, 4'b0100); idle(1);

    // ch3 left pending with no response
    clear_tallies();
    step(4'b1000, '0, '0); idle(20);
`ifdef REQUEST_TRACKER_TIMEOUT_EN
    check("d_timed_out", 32'(n_to[3]),       32'd1);
    check("d_pending",   32'(pending_count), 32'd0);
    clear_tallies();
    step(4'b1000, '0, '0); idle(15); step('0, 4'b1000, '0); idle(10);
    check("d2_timed_out", 32'(n_to[3]),   32'd0);
    check("d2_busy",      32'(n_busy[3]), 32'd8);
`else
    check("d_timed_out", 32'(n_to[3]),       32'd0);
    check("d_pending",   32'(pending_count), 32'd1);
    step('0, '0, 4'b1000); idle(1);
`endif

    // request in the final BUSY cycle is dropped
    clear_tallies();
    step(4'b0001, '0, '0); idle(2); step('0, 4'b0001, '0); idle(7);
    step(4'b0001, '0, '0); idle(4);
    check("e_dropped_pc", 32'(pending_count), 32'd0);
    check("e_busy",       32'(n_busy[0]),     32'd8);

    // all channels pending, then asynchronous reset at cycle 5
    step(4'b1111, '0, '0);
    check("f_pc4", 32'(pending_count), 32'd4);
    step('0, 4'b0011, '0); idle(3);
    async_reset("f_rst");
    clear_tallies();
    step(4'b0001, '0, '0); idle(2);
    check("f_after_pc", 32'(pending_count), 32'd1);
    check("f_no_pulse", 32'(n_ab[0] + n_done[0] + n_to[0]), 32'd0);
    step('0, '0, 4'b0001); idle(1);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
           4'($urandom) & 4'($urandom),
           4'($urandom) & 4'($urandom) & 4'($urandom));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_request_tracker.md
MULTI_CHANNEL_REQUEST_TRACKER -- requirements
Module: multi_channel_request_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, 4, number of independent channels (1..32).
REQ-002 SHALL have parameter BUSY_LEN, 8, cycles busy stays high per accepted request (1..255).
REQ-003 SHALL have parameter TIMEOUT, 16, max PENDING cycles before auto-abort (1..255); used only with the timeout macro.
REQ-004 SHALL have port clk input 1, single clock; all state on posedge clk.
REQ-005 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have port request input NUM_CH, per-channel request pulse.
REQ-007 SHALL have port accept input NUM_CH, per-channel accept from downstream.
REQ-008 SHALL have port cancel input NUM_CH, per-channel cancel from requester.
REQ-009 SHALL have port busy output NUM_CH, registered, high only while the channel is in BUSY.
REQ-010 SHALL have port done output NUM_CH, one-cycle pulse in the final BUSY cycle.
REQ-011 SHALL have port aborted output NUM_CH, one-cycle pulse when PENDING ends by cancel.
REQ-012 SHALL have port timed_out output NUM_CH, one-cycle pulse when PENDING ends by timeout.
REQ-013 SHALL have port pending_count output $clog2(NUM_CH+1), number of channels currently PENDING.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, PENDING, BUSY.
REQ-015 IDLE: request=1 -> PENDING next cycle; accept/cancel in IDLE ignored.
REQ-016 Accept and cancel in the same cycle as the accepted request SHALL be ignored; they are sampled from the first PENDING cycle on.
REQ-017 PENDING: cancel=1 -> IDLE next cycle, aborted pulses in that next cycle.
REQ-018 PENDING: accept=1 and cancel=0 -> BUSY next cycle; busy rises in that cycle.
REQ-019 PENDING: accept=1 and cancel=1 in the same cycle -> cancel wins (IDLE, aborted), no busy.
REQ-020 BUSY SHALL last exactly BUSY_LEN cycles via a down-counter loaded with BUSY_LEN-1; done=1 when counter is 0, then IDLE.
REQ-021 request, accept, cancel in PENDING (request only) or BUSY (all) SHALL be ignored; no queuing; request in the final BUSY cycle is dropped.
REQ-022 busy SHALL never rise without a preceding PENDING interval ended by accept without cancel.
REQ-023 pending_count SHALL equal the popcount of channels in PENDING, registered consistently with state (same-cycle view).
REQ-024 Counter widths SHALL be 8 bits; no wrap-around is possible within parameter ranges.

Reset
REQ-025 rst_n=0 SHALL asynchronously force all channels to IDLE, clear all counters, and drive busy, done, aborted, timed_out, pending_count to 0.
REQ-026 Reset asserted mid-PENDING or mid-BUSY SHALL abort silently (no aborted/done/timed_out pulse); first request after deassertion is accepted normally.

Configuration
REQ-027 With REQUEST_TRACKER_TIMEOUT_EN defined, a PENDING channel with no accept/cancel for TIMEOUT consecutive PENDING cycles SHALL return to IDLE with timed_out pulsing the next cycle; accept or cancel in the TIMEOUT-th cycle takes precedence over timeout.
REQ-028 Without REQUEST_TRACKER_TIMEOUT_EN, PENDING SHALL persist indefinitely, the pending counter SHALL not be built, and timed_out SHALL be tied 0.

Structure
REQ-029 Package multi_channel_request_tracker_pkg SHALL hold the state enum typedef (IDLE, PENDING, BUSY) and default constants for BUSY_LEN, TIMEOUT, counter width.
REQ-030 Per-channel logic SHALL be sub-module request_tracker_channel, instantiated NUM_CH times by generate; top adds pending_count popcount.

Verification
REQ-031 NUM_CH=4, BUSY_LEN=8: request[0] at cycle 0, accept[0] at cycle 3 -> busy[0] high cycles 4..11, done[0] at cycle 11, IDLE at 12.
REQ-032 request[1] at cycle 0, cancel[1] at cycle 2 -> aborted[1] at cycle 3, busy[1] never rises; accept[1]+cancel[1] both at cycle 2 -> same result.
REQ-033 request[2] and accept[2] both at cycle 0, no later accept -> channel stays PENDING, busy[2]=0, pending_count=1.
REQ-034 With REQUEST_TRACKER_TIMEOUT_EN, TIMEOUT=16: request[3] at cycle 0, no accept/cancel -> timed_out[3] at cycle 17; accept at cycle 16 instead -> busy at 17, no timed_out.
REQ-035 All four channels requested at cycle 0 -> pending_count=4 at cycle 1; rst_n=0 at cycle 5 -> all outputs 0 immediately, no pulses.
REQ-036 Bench SHALL assert REQ-022 as a property on every channel across all scenarios and random stimulus.
